acc_domain_ctrl: RTL and testbench
==================================

ACC_DOMAIN_CTRL -- requirements
Module: acc_domain_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent accelerator core domains, range 1..16.
REQ-002 SHALL have parameter DLY_W, default 3: width of the wake-delay configuration and counter.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 4, range 1..2**DLY_W: cycles the clock is held on with reset asserted before gating.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_i, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port core_en_i, input, NUM_CH: per-channel enable, asynchronous to clk_i.
REQ-007 SHALL have port on_delay_i, input, DLY_W: wake delay D, sampled per channel on entry to WAKE.
REQ-008 SHALL have port clk_core_o, output, NUM_CH: per-channel gated core clock.
REQ-009 SHALL have port reset_core_o, output, NUM_CH: per-channel active-high core reset.
REQ-010 SHALL have port ready_o, output, NUM_CH: channel is in RUN.
REQ-011 SHALL have port busy_o, output, NUM_CH: channel is in WAKE or DRAIN.

Function
REQ-012 SHALL pass each core_en_i bit through a two-flop synchronizer; en_s[c] is valid two edges after capture.
REQ-013 SHALL run one Moore FSM per channel with states OFF, WAKE, RUN and DRAIN; all outputs decode from registered state only.
REQ-014 OFF: clock enable 0, reset_core_o=1, ready_o=0, busy_o=0; if en_s=1, go to WAKE, load cnt=0 and latch D=on_delay_i.
REQ-015 WAKE: clock enable 1, reset_core_o=1, busy_o=1; cnt increments each cycle; when cnt==D go to RUN; WAKE lasts D+1 cycles, including D=0.
REQ-016 WAKE with en_s=0: go directly to OFF, with no drain, because the core has never left reset.
REQ-017 RUN: clock enable 1, reset_core_o=0, ready_o=1; if en_s=0, go to DRAIN and load cnt=0.
REQ-018 DRAIN: clock enable 1, reset_core_o=1, busy_o=1; when cnt==DRAIN_CYCLES-1 go to OFF.
REQ-019 DRAIN SHALL always complete; en_s re-asserting during DRAIN SHALL NOT shorten it; the channel passes through OFF for at least one cycle before a new WAKE.
REQ-020 Latency: core_en_i rising, captured at edge N, gives the clock enable active after edge N+2 and reset_core_o low after edge N+3+D.
REQ-021 reset_core_o SHALL always be asserted at least one cycle before the clock enable drops, and the clock enable raised at least one cycle before reset_core_o releases, except under reset_i.
REQ-022 The counter SHALL be DLY_W bits wide and never wrap: it is compared for equality before any increment.
REQ-023 Channels SHALL be fully independent; simultaneous transitions on different channels SHALL NOT interact.

Reset
REQ-024 reset_i=1 at an edge SHALL force every channel to OFF, cnt=0, synchronizer flops=0 and latched D=0, in any state including mid-RUN or mid-DRAIN.
REQ-025 Outputs after reset: reset_core_o all 1, ready_o 0, busy_o 0, clock enable 0.
REQ-026 Reset wins over any core_en_i activity in the same cycle.

Configuration
REQ-027 With ACC_DOMAIN_CLKGATE_EN defined, each clk_core_o[c] SHALL come from one util_clkgate instance with en_i set to the channel clock enable and testmode_i=0.
REQ-028 Without ACC_DOMAIN_CLKGATE_EN, clk_core_o[c] SHALL equal clk_i (FPGA build), with the FSM, reset_core_o and status outputs unchanged.

Structure
REQ-029 Package acc_domain_pkg SHALL hold the state encoding (OFF=0, WAKE=1, RUN=2, DRAIN=3) and the defaults of NUM_CH, DLY_W and DRAIN_CYCLES.
REQ-030 Sub-module acc_domain_ch SHALL hold the synchronizer, FSM, counter and clock gate for one channel; acc_domain_ctrl SHALL instantiate NUM_CH copies via generate.

Verification
REQ-031 Power-up: on_delay_i=7, core_en_i[0] 0->1 at edge N -> clock enable 1 after N+2, reset_core_o[0]=0 and ready_o[0]=1 after N+10, busy_o[0]=1 for cycles N+2..N+9.
REQ-032 D=0: on_delay_i=0, enable channel 1 -> reset_core_o[1] low exactly one cycle after the clock enable rises.
REQ-033 Power-down: channel in RUN, core_en_i 1->0 -> reset_core_o 1 two edges later, clock stays enabled 4 cycles (DRAIN_CYCLES=4), then OFF; check clk_core_o has no pulse after OFF.
REQ-034 Re-enable in DRAIN: core_en_i pulses back to 1 in DRAIN cycle 1 -> DRAIN runs its full 4 cycles, then one OFF cycle, then WAKE.
REQ-035 Abort wake: core_en_i drops during WAKE with D=7 -> OFF with no DRAIN, and reset_core_o never deasserts.
REQ-036 Mid-run reset and independence: ch0 in RUN and ch1 in WAKE, reset_i pulsed one cycle -> both OFF after that edge, all outputs at reset values; repeat without reset toggling ch1 only -> ch0 outputs unchanged.

Source files
------------

// File: rtl/acc_domain_pkg.sv
// Shared types and default parameters for the accelerator domain controller.
package acc_domain_pkg;

  localparam int NUM_CH_DEF       = 2;
  localparam int DLY_W_DEF        = 3;
  localparam int DRAIN_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WAKE  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } ch_state_e;

endpackage

// File: rtl/acc_domain_ch.sv
// One accelerator core domain: enable synchronizer, power sequencing FSM,
// shared wake/drain counter and the core clock gate.
// Optional feature macro: ACC_DOMAIN_CLKGATE_EN (real clock gate instead of
// passing clk_i straight through).
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_OFF   | clock gated, core held in reset
// ST_WAKE  | clock running, core still in reset for D+1 cycles
// ST_RUN   | clock running, core out of reset
// ST_DRAIN | core back in reset, clock kept on DRAIN_CYCLES cycles
module acc_domain_ch
  import acc_domain_pkg::*;
#(
  parameter int DLY_W        = DLY_W_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [DLY_W-1:0] on_delay_i,
  output logic             clk_core_o,
  output logic             reset_core_o,
  output logic             ready_o,
  output logic             busy_o
);

  // Terminal count of the drain phase; fits DLY_W since DRAIN_CYCLES <= 2**DLY_W.
  localparam logic [DLY_W-1:0] DRAIN_LAST = DLY_W'(DRAIN_CYCLES - 1);

  ch_state_e        state, state_nxt;
  logic [DLY_W-1:0] cnt, cnt_nxt;
  logic [DLY_W-1:0] dly, dly_nxt;
  logic [1:0]       sync;
  logic             en_s;

  assign en_s = sync[1];

  // State, counter, latched delay and synchronizer registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= ST_OFF;
      cnt   <= '0;
      dly   <= '0;
      sync  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dly   <= dly_nxt;
      sync  <= {sync[0], en_i};
    end
  end

  // Next-state and counter logic; the counter is compared before it increments
  // so it never wraps.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dly_nxt   = dly;
    unique case (state)
      ST_OFF: begin
        if (en_s) begin
          state_nxt = ST_WAKE;
          cnt_nxt   = '0;
          dly_nxt   = on_delay_i;
        end
      end
      ST_WAKE: begin
        // Core never left reset, so an abort needs no drain.
        if (!en_s)            state_nxt = ST_OFF;
        else if (cnt == dly)  state_nxt = ST_RUN;
        else                  cnt_nxt   = cnt + 1'b1;
      end
      ST_RUN: begin
        if (!en_s) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = '0;
        end
      end
      ST_DRAIN: begin
        // Ignores en_s: drain always runs to completion.
        if (cnt == DRAIN_LAST) state_nxt = ST_OFF;
        else                   cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = ST_OFF;
    endcase
  end

  // Moore output decode from the registered state.
  always_comb begin
    reset_core_o = 1'b1;
    ready_o      = 1'b0;
    busy_o       = 1'b0;
    case (state)
      ST_WAKE, ST_DRAIN: busy_o = 1'b1;
      ST_RUN: begin
        reset_core_o = 1'b0;
        ready_o      = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ACC_DOMAIN_CLKGATE_EN
  logic clk_en;
  assign clk_en = (state != ST_OFF);

  util_clkgate u_clkgate (
    .clk_i      (clk_i),
    .en_i       (clk_en),
    .testmode_i (1'b0),
    .clk_o      (clk_core_o)
  );
`else
  // FPGA build: core clock is free-running, sequencing is by reset only.
  assign clk_core_o = clk_i;
`endif

endmodule

// File: rtl/acc_domain_ctrl.sv
// Power/clock/reset sequencer for NUM_CH independent accelerator core domains.
// Optional feature macro: ACC_DOMAIN_CLKGATE_EN (per-channel clock gating).
module acc_domain_ctrl
  import acc_domain_pkg::*;
#(
  parameter int NUM_CH       = NUM_CH_DEF,
  parameter int DLY_W        = DLY_W_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [NUM_CH-1:0] core_en_i,
  input  logic [DLY_W-1:0]  on_delay_i,
  output logic [NUM_CH-1:0] clk_core_o,
  output logic [NUM_CH-1:0] reset_core_o,
  output logic [NUM_CH-1:0] ready_o,
  output logic [NUM_CH-1:0] busy_o
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    acc_domain_ch #(
      .DLY_W        (DLY_W),
      .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_ch (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .en_i         (core_en_i[c]),
      .on_delay_i   (on_delay_i),
      .clk_core_o   (clk_core_o[c]),
      .reset_core_o (reset_core_o[c]),
      .ready_o      (ready_o[c]),
      .busy_o       (busy_o[c])
    );
  end

endmodule

// File: tb/tb_acc_domain_ctrl.sv
// Self-checking bench for acc_domain_ctrl (default build, no clock gating).
module tb_acc_domain_ctrl;

  localparam int NUM_CH       = 2;
  localparam int DLY_W        = 3;
  localparam int DRAIN_CYCLES = 4;

  logic              clk = 1'b0;
  logic              reset_i;
  logic [NUM_CH-1:0] core_en_i;
  logic [DLY_W-1:0]  on_delay_i;
  logic [NUM_CH-1:0] clk_core_o, reset_core_o, ready_o, busy_o;

  int vectors = 0;
  int miscompares = 0;

  acc_domain_ctrl #(
    .NUM_CH       (NUM_CH),
    .DLY_W        (DLY_W),
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .core_en_i    (core_en_i),
    .on_delay_i   (on_delay_i),
    .clk_core_o   (clk_core_o),
    .reset_core_o (reset_core_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  // Reference model: a clock-on flag, a core-in-reset flag and two
  // remaining-cycle timers per channel, plus a two-deep enable delay line.
  int m_s1[NUM_CH], m_s2[NUM_CH], m_wake[NUM_CH], m_drain[NUM_CH];
  bit m_clk_on[NUM_CH], m_in_rst[NUM_CH];

  always @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset_i) begin
        m_s1[c] = 0; m_s2[c] = 0; m_wake[c] = 0; m_drain[c] = 0;
        m_clk_on[c] = 1'b0; m_in_rst[c] = 1'b1;
      end else begin
        if (!m_clk_on[c]) begin
          if (m_s2[c] != 0) begin
            m_clk_on[c] = 1'b1;
            m_wake[c]   = int'(on_delay_i) + 1;
          end
        end else if (m_wake[c] > 0) begin
          if (m_s2[c] == 0) begin
            m_clk_on[c] = 1'b0;
            m_wake[c]   = 0;
          end else begin
            m_wake[c]--;
            if (m_wake[c] == 0) m_in_rst[c] = 1'b0;
          end
        end else if (m_drain[c] > 0) begin
          m_drain[c]--;
          if (m_drain[c] == 0) m_clk_on[c] = 1'b0;
        end else if (m_s2[c] == 0) begin
          m_in_rst[c] = 1'b1;
          m_drain[c]  = DRAIN_CYCLES;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = int'(core_en_i[c]);
      end
    end
  end

  // {reset_core, ready, busy} as predicted by the model.
  function automatic logic [3*NUM_CH-1:0] model_out();
    logic [NUM_CH-1:0] r, rd, b;
    for (int c = 0; c < NUM_CH; c++) begin
      r[c]  = m_in_rst[c];
      rd[c] = !m_in_rst[c];
      b[c]  = m_clk_on[c] && m_in_rst[c];
    end
    return {r, rd, b};
  endfunction

  task automatic do_reset();
    reset_i   = 1'b1;
    core_en_i = '0;
    @(negedge clk);
    reset_i   = 1'b0;
  endtask

  task automatic test_reset();
    reset_i    = 1'b1;
    core_en_i  = '1;
    on_delay_i = 3'd5;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if ({reset_core_o, ready_o, busy_o} !== {2'b11, 2'b00, 2'b00}) begin
        miscompares++;
        $display("FAIL reset_values k=%0d: got %b expected %b", k,
                 {reset_core_o, ready_o, busy_o}, {2'b11, 2'b00, 2'b00});
      end
      vectors++;
      if ({reset_core_o, ready_o, busy_o} !== model_out()) begin
        miscompares++;
        $display("FAIL reset_model k=%0d: got %b expected %b", k,
                 {reset_core_o, ready_o, busy_o}, model_out());
      end
    end
    vectors++;
    if (clk_core_o !== 2'b00) begin
      miscompares++;
      $display("FAIL clk_core_low: got %b expected 00", clk_core_o);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (clk_core_o !== 2'b11) begin
      miscompares++;
      $display("FAIL clk_core_high: got %b expected 11", clk_core_o);
    end
    @(negedge clk);
    core_en_i = '0;
    reset_i   = 1'b0;
  endtask

  task automatic test_power_up();
    logic eb, er;
    do_reset();
    on_delay_i = 3'd7;
    core_en_i  = 2'b01;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      eb = (k >= 2 && k <= 9);
      er = (k >= 10);
      vectors++;
      if ({busy_o[0], ready_o[0], reset_core_o[0]} !== {eb, er, !er}) begin
        miscompares++;
        $display("FAIL power_up k=%0d: got b/r/rc=%b expected %b", k,
                 {busy_o[0], ready_o[0], reset_core_o[0]}, {eb, er, !er});
      end
      vectors++;
      if ({reset_core_o, ready_o, busy_o} !== model_out()) begin
        miscompares++;
        $display("FAIL power_up_model k=%0d: got %b expected %b", k,
                 {reset_core_o, ready_o, busy_o}, model_out());
      end
    end
  endtask

  task automatic test_d0();
    logic eb, er;
    do_reset();
    on_delay_i = 3'd0;
    core_en_i  = 2'b10;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      eb = (k == 2);
      er = (k >= 3);
      vectors++;
      if ({busy_o[1], ready_o[1], reset_core_o[1], ready_o[0], busy_o[0]} !==
          {eb, er, !er, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL d0 k=%0d: got %b expected %b", k,
                 {busy_o[1], ready_o[1], reset_core_o[1], ready_o[0], busy_o[0]},
                 {eb, er, !er, 1'b0, 1'b0});
      end
    end
  endtask

  task automatic test_power_down();
    logic eb, er;
    do_reset();
    on_delay_i = 3'd2;
    core_en_i  = 2'b01;
    repeat (8) @(negedge clk);
    vectors++;
    if (ready_o[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL power_down_setup: ready got %b expected 1", ready_o[0]);
    end
    core_en_i = 2'b00;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      er = (k <= 1);
      eb = (k >= 2 && k <= 5);
      vectors++;
      if ({busy_o[0], ready_o[0], reset_core_o[0]} !== {eb, er, !er}) begin
        miscompares++;
        $display("FAIL power_down k=%0d: got b/r/rc=%b expected %b", k,
                 {busy_o[0], ready_o[0], reset_core_o[0]}, {eb, er, !er});
      end
      vectors++;
      if ({reset_core_o, ready_o, busy_o} !== model_out()) begin
        miscompares++;
        $display("FAIL power_down_model k=%0d: got %b expected %b", k,
                 {reset_core_o, ready_o, busy_o}, model_out());
      end
    end
  endtask

  task automatic test_reenable_drain();
    logic eb, er;
    do_reset();
    on_delay_i = 3'd1;
    core_en_i  = 2'b01;
    repeat (8) @(negedge clk);
    core_en_i = 2'b00;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      er = (k <= 1) || (k >= 9);
      eb = (k >= 2 && k <= 5) || (k == 7) || (k == 8);
      vectors++;
      if ({busy_o[0], ready_o[0], reset_core_o[0]} !== {eb, er, !er}) begin
        miscompares++;
        $display("FAIL reenable_drain k=%0d: got b/r/rc=%b expected %b", k,
                 {busy_o[0], ready_o[0], reset_core_o[0]}, {eb, er, !er});
      end
      vectors++;
      if ({reset_core_o, ready_o, busy_o} !== model_out()) begin
        miscompares++;
        $display("FAIL reenable_drain_model k=%0d: got %b expected %b", k,
                 {reset_core_o, ready_o, busy_o}, model_out());
      end
      if (k == 2) core_en_i = 2'b01;
    end
  endtask

  task automatic test_abort_wake();
    logic eb;
    do_reset();
    on_delay_i = 3'd7;
    core_en_i  = 2'b01;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      eb = (k >= 2 && k <= 7);
      vectors++;
      if ({busy_o[0], ready_o[0], reset_core_o[0]} !== {eb, 1'b0, 1'b1}) begin
        miscompares++;
        $display("FAIL abort_wake k=%0d: got b/r/rc=%b expected %b", k,
                 {busy_o[0], ready_o[0], reset_core_o[0]}, {eb, 1'b0, 1'b1});
      end
      if (k == 5) core_en_i = 2'b00;
    end
  endtask

  task automatic test_midrun_reset();
    logic [NUM_CH-1:0] en1;
    do_reset();
    on_delay_i = 3'd1;
    core_en_i  = 2'b01;
    repeat (6) @(negedge clk);
    on_delay_i = 3'd7;
    core_en_i  = 2'b11;
    repeat (4) @(negedge clk);
    vectors++;
    if ({ready_o[0], busy_o[1]} !== 2'b11) begin
      miscompares++;
      $display("FAIL midrun_setup: got ready0/busy1=%b expected 11", {ready_o[0], busy_o[1]});
    end
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    vectors++;
    if ({reset_core_o, ready_o, busy_o} !== {2'b11, 2'b00, 2'b00}) begin
      miscompares++;
      $display("FAIL midrun_reset: got %b expected %b",
               {reset_core_o, ready_o, busy_o}, {2'b11, 2'b00, 2'b00});
    end
    do_reset();
    on_delay_i = 3'd0;
    core_en_i  = 2'b01;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        en1 = core_en_i;
        en1[1] = ~en1[1];
        core_en_i = en1;
      end
      on_delay_i = DLY_W'($urandom_range(0, 3));
      @(negedge clk);
      vectors++;
      if ({reset_core_o[0], ready_o[0], busy_o[0]} !== 3'b010) begin
        miscompares++;
        $display("FAIL independence k=%0d: ch0 got rc/r/b=%b expected 010", k,
                 {reset_core_o[0], ready_o[0], busy_o[0]});
      end
      vectors++;
      if ({reset_core_o, ready_o, busy_o} !== model_out()) begin
        miscompares++;
        $display("FAIL independence_model k=%0d: got %b expected %b", k,
                 {reset_core_o, ready_o, busy_o}, model_out());
      end
    end
  endtask

  task automatic test_random();
    int ch;
    logic [NUM_CH-1:0] en;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      reset_i = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 5) == 0) begin
        ch = int'($urandom_range(0, NUM_CH - 1));
        en = core_en_i;
        en[ch] = ~en[ch];
        core_en_i = en;
      end
      if ($urandom_range(0, 1) == 0) on_delay_i = DLY_W'($urandom_range(0, 7));
      @(negedge clk);
      vectors++;
      if ({reset_core_o, ready_o, busy_o} !== model_out()) begin
        miscompares++;
        $display("FAIL random i=%0d: got %b expected %b", i,
                 {reset_core_o, ready_o, busy_o}, model_out());
      end
    end
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i    = 1'b1;
    core_en_i  = '0;
    on_delay_i = '0;
    @(negedge clk);
    test_reset();
    test_power_up();
    test_d0();
    test_power_down();
    test_reenable_drain();
    test_abort_wake();
    test_midrun_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
